// File: rtl/enable_divider_bank.sv
// enable_divider_bank: a bank of independent, runtime-programmable clock-enable
// dividers. Each channel counts system clock edges up to its divisor and emits a
// one-cycle registered enable pulse, either periodically or as a one-shot timer.
module enable_divider_bank #(
  parameter int          CHANNELS        = 4,
  parameter int          WIDTH           = 32,
  parameter int unsigned DEFAULT_DIVISOR = 50000000,
  parameter int          CH_BITS         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cfg_valid_i,
  input  logic [CH_BITS-1:0]  cfg_channel_i,
  input  logic [WIDTH-1:0]    cfg_divisor_i,
  input  logic                cfg_oneshot_i,
  input  logic                sync_i,
  input  logic [CHANNELS-1:0] run_i,
  output logic [CHANNELS-1:0] pulse_o,
  output logic [CHANNELS-1:0] busy_o
);

  logic [CHANNELS-1:0][WIDTH-1:0] count_q,   count_d;
  logic [CHANNELS-1:0][WIDTH-1:0] divisor_q, divisor_d;
  logic [CHANNELS-1:0]            oneshot_q, oneshot_d;
  logic [CHANNELS-1:0]            busy_q,    busy_d;
  logic [CHANNELS-1:0]            pulse_q,   pulse_d;
  logic [CHANNELS-1:0]            writeHit;

  // A write addresses exactly one channel; an index beyond the bank matches none.
  always_comb begin
    writeHit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      writeHit[i] = cfg_valid_i && (cfg_channel_i == CH_BITS'(i));
    end
  end

  // Per-channel next state: config write beats sync, sync beats counting.
  always_comb begin
    count_d   = count_q;
    divisor_d = divisor_q;
    oneshot_d = oneshot_q;
    busy_d    = busy_q;
    pulse_d   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (writeHit[i]) begin
        divisor_d[i] = cfg_divisor_i;
        oneshot_d[i] = cfg_oneshot_i;
        count_d[i]   = '0;
        busy_d[i]    = cfg_oneshot_i && (cfg_divisor_i != '0);
      end else if (sync_i) begin
        count_d[i] = '0;
      end else if (divisor_q[i] == '0) begin
        busy_d[i] = 1'b0;
      end else if (run_i[i] && (!oneshot_q[i] || busy_q[i])) begin
        if (count_q[i] == divisor_q[i] - WIDTH'(1)) begin
          count_d[i] = '0;
          pulse_d[i] = 1'b1;
          if (oneshot_q[i]) begin
            busy_d[i] = 1'b0;
          end
        end else begin
          count_d[i] = count_q[i] + WIDTH'(1);
        end
      end
    end
  end

  // State registers; reset restores the default divisor in periodic mode.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q   <= '0;
      divisor_q <= {CHANNELS{WIDTH'(DEFAULT_DIVISOR)}};
      oneshot_q <= '0;
      busy_q    <= '0;
      pulse_q   <= '0;
    end else begin
      count_q   <= count_d;
      divisor_q <= divisor_d;
      oneshot_q <= oneshot_d;
      busy_q    <= busy_d;
      pulse_q   <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_enable_divider_bank.sv
// tb_enable_divider_bank: directed scenarios plus randomized traffic, checked
// every cycle against a countdown model of each channel's remaining edges.
module tb_enable_divider_bank;

  localparam int CHANNELS = 4;
  localparam int WIDTH    = 8;
  localparam int DEF_DIV  = 5;
  localparam int CH_BITS  = 3;

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  logic                cfgValid = 1'b0;
  logic [CH_BITS-1:0]  cfgChannel = '0;
  logic [WIDTH-1:0]    cfgDivisor = '0;
  logic                cfgOneshot = 1'b0;
  logic                syncIn = 1'b0;
  logic [CHANNELS-1:0] runIn = '0;
  logic [CHANNELS-1:0] pulseOut;
  logic [CHANNELS-1:0] busyOut;

  int total = 0;
  int bad   = 0;

  int unsigned mDiv[CHANNELS];
  int unsigned mRem[CHANNELS];
  bit          mOs[CHANNELS];
  bit          mBusy[CHANNELS];
  bit          mPulse[CHANNELS];
  int          pulseCnt[CHANNELS];

  enable_divider_bank #(
    .CHANNELS(CHANNELS),
    .WIDTH(WIDTH),
    .DEFAULT_DIVISOR(DEF_DIV),
    .CH_BITS(CH_BITS)
  ) dut (
    .clock(clock),
    .reset(reset),
    .cfg_valid_i(cfgValid),
    .cfg_channel_i(cfgChannel),
    .cfg_divisor_i(cfgDivisor),
    .cfg_oneshot_i(cfgOneshot),
    .sync_i(syncIn),
    .run_i(runIn),
    .pulse_o(pulseOut),
    .busy_o(busyOut)
  );

  // 10 ns system clock
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Model: each channel tracks how many counting edges remain before it fires.
  task automatic modelEdge(input bit rst, input bit cv, input int cch,
                           input int unsigned cdiv, input bit cos, input bit sy,
                           input logic [CHANNELS-1:0] rn);
    for (int i = 0; i < CHANNELS; i++) begin
      if (rst) begin
        mDiv[i] = DEF_DIV; mRem[i] = DEF_DIV; mOs[i] = 0; mBusy[i] = 0; mPulse[i] = 0;
      end else if (cv && cch == i) begin
        mDiv[i] = cdiv; mRem[i] = cdiv; mOs[i] = cos;
        mBusy[i] = cos && (cdiv != 0); mPulse[i] = 0;
      end else if (sy) begin
        mRem[i] = mDiv[i]; mPulse[i] = 0;
      end else begin
        mPulse[i] = 0;
        if (mDiv[i] == 0) begin
          mBusy[i] = 0;
        end else if (rn[i] && (!mOs[i] || mBusy[i])) begin
          mRem[i] = mRem[i] - 1;
          if (mRem[i] == 0) begin
            mPulse[i] = 1;
            mRem[i] = mDiv[i];
            if (mOs[i]) mBusy[i] = 0;
          end
        end
      end
    end
  endtask

  // Drive one cycle of inputs, advance model on the edge, compare just after it.
  task automatic applyStimulus(input bit rst, input bit cv, input int cch,
                               input int unsigned cdiv, input bit cos, input bit sy,
                               input logic [CHANNELS-1:0] rn);
    logic [CHANNELS-1:0] expPulse;
    logic [CHANNELS-1:0] expBusy;
    reset = rst; cfgValid = cv; cfgChannel = CH_BITS'(cch);
    cfgDivisor = WIDTH'(cdiv); cfgOneshot = cos; syncIn = sy; runIn = rn;
    @(posedge clock);
    modelEdge(rst, cv, cch, cdiv, cos, sy, rn);
    #1;
    for (int i = 0; i < CHANNELS; i++) begin
      expPulse[i] = mPulse[i];
      expBusy[i]  = mBusy[i];
      if (pulseOut[i]) pulseCnt[i]++;
    end
    checkOutput("pulse", 32'(pulseOut), 32'(expPulse));
    checkOutput("busy", 32'(busyOut), 32'(expBusy));
  endtask

  task automatic idle(input int n, input logic [CHANNELS-1:0] rn);
    for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, 0, 0, rn);
  endtask

  task automatic clearCounts();
    for (int i = 0; i < CHANNELS; i++) pulseCnt[i] = 0;
  endtask

  initial begin
    // Reset state
    applyStimulus(1, 0, 0, 0, 0, 0, 4'b0000);
    checkOutput("rstPulse", 32'(pulseOut), 32'd0);
    checkOutput("rstBusy", 32'(busyOut), 32'd0);

    // Default divisor: five pulses per channel in 25 running cycles
    clearCounts();
    idle(25, 4'b1111);
    for (int i = 0; i < CHANNELS; i++) checkOutput("defCount", 32'(pulseCnt[i]), 32'd5);

    // ch2 divisor 3 periodic, ch1 divisor 1 (continuous)
    applyStimulus(0, 1, 2, 3, 0, 0, 4'b1111);
    applyStimulus(0, 1, 1, 1, 0, 0, 4'b1111);
    clearCounts();
    idle(30, 4'b1111);
    checkOutput("ch1Cont", 32'(pulseCnt[1]), 32'd30);
    checkOutput("ch2Div3", 32'(pulseCnt[2]), 32'd10);

    // ch0 one-shot divisor 4: single pulse, then rearm by rewrite
    applyStimulus(0, 1, 0, 4, 1, 0, 4'b1111);
    checkOutput("osArmed", 32'(busyOut[0]), 32'd1);
    clearCounts();
    idle(20, 4'b1111);
    checkOutput("osOnce", 32'(pulseCnt[0]), 32'd1);
    applyStimulus(0, 1, 0, 4, 1, 0, 4'b1111);
    clearCounts();
    idle(12, 4'b1111);
    checkOutput("osRearm", 32'(pulseCnt[0]), 32'd1);

    // ch3 divisor 6: pause at count 2 for 7 cycles, then sync on a terminal edge
    applyStimulus(0, 1, 3, 6, 0, 0, 4'b1111);
    idle(2, 4'b1111);
    idle(7, 4'b0111);
    idle(4, 4'b1111);
    checkOutput("pausePulse", 32'(pulseOut[3]), 32'd1);
    applyStimulus(0, 1, 3, 6, 0, 0, 4'b1111);
    idle(5, 4'b1111);
    applyStimulus(0, 0, 0, 0, 0, 1, 4'b1111);
    checkOutput("syncSupp", 32'(pulseOut[3]), 32'd0);
    idle(12, 4'b1111);

    // Write to ch1 on its terminal edge, then an out-of-range write
    applyStimulus(0, 1, 1, 1, 0, 0, 4'b1111);
    applyStimulus(0, 1, 1, 3, 0, 0, 4'b1111);
    checkOutput("wrSupp", 32'(pulseOut[1]), 32'd0);
    applyStimulus(0, 1, 5, 2, 1, 0, 4'b1111);
    idle(12, 4'b1111);

    // Reset in the middle of a one-shot
    applyStimulus(0, 1, 0, 4, 1, 0, 4'b1111);
    idle(2, 4'b1111);
    applyStimulus(1, 0, 0, 0, 0, 0, 4'b1111);
    checkOutput("midRstBusy", 32'(busyOut), 32'd0);
    checkOutput("midRstPulse", 32'(pulseOut), 32'd0);
    clearCounts();
    idle(10, 4'b1111);
    checkOutput("midRstDiv", 32'(pulseCnt[0]), 32'd2);

    // Divisor 0 never pulses
    applyStimulus(0, 1, 2, 0, 0, 0, 4'b1111);
    clearCounts();
    idle(300, 4'b1111);
    checkOutput("div0", 32'(pulseCnt[2]), 32'd0);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      bit rst, cv, cos, sy;
      int cch;
      int unsigned cdiv;
      logic [CHANNELS-1:0] rn;
      rst  = ($urandom_range(0, 499) == 0);
      cv   = ($urandom_range(0, 15) == 0);
      cch  = $urandom_range(0, 7);
      cdiv = $urandom_range(0, 7);
      cos  = $urandom_range(0, 1);
      sy   = ($urandom_range(0, 63) == 0);
      rn   = CHANNELS'($urandom) | CHANNELS'($urandom);
      applyStimulus(rst, cv, cch, cdiv, cos, sy, rn);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
